fma16_result_checker: RTL and testbench

Hardware response-side checker for the fma16 test flow. It consumes one test record per handshake: the vector operands, the expected result and flags, and the result and flags the fma16 produced. It compares them, counts vectors and errors, and logs the first mismatches in a small FIFO that a host or bench drains. It is the receiving end of the vector stream that the vector driver produces, so regressions can run without a simulator-side compare.

---
 rtl/fma16_result_checker.sv | 120 ++++++++++++
 tb/tb_fma16_result_checker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fma16_result_checker.sv
// Response-side checker for the fma16 vector flow: compares each record, counts vectors and
// mismatches, and keeps the first mismatches in a small drainable log FIFO.
module fma16_result_checker #(
  parameter int unsigned ERR_DEPTH   = 8,
  parameter bit          CHECK_FLAGS = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [15:0]  vec_x,
  input  logic [15:0]  vec_y,
  input  logic [15:0]  vec_z,
  input  logic [15:0]  vec_rexp,
  input  logic [3:0]   vec_fexp,
  input  logic [15:0]  dut_result,
  input  logic [3:0]   dut_flags,
  output logic         log_valid,
  input  logic         log_ready,
  output logic [103:0] log_data,
  output logic         busy,
  output logic         done,
  output logic         log_overflow,
  output logic [31:0]  vec_count,
  output logic [31:0]  err_count
);

  localparam int unsigned AW = $clog2(ERR_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   vec_cnt_q, vec_cnt_d, err_cnt_q, err_cnt_d;
  logic          ovf_q, ovf_d;
  logic [103:0]  mem_q [ERR_DEPTH];

  logic accept, mismatch, empty, full, push_req, push_ok, pop;
  logic [103:0] entry;

  assign in_ready = (state_q == StRun) && !start;
  assign accept   = in_valid && in_ready;
  assign mismatch = (dut_result != vec_rexp) || (CHECK_FLAGS && (dut_flags != vec_fexp));

  // Extra pointer MSB distinguishes full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign push_req = accept && mismatch;
  assign pop      = !empty && log_ready && !start;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
  assign push_ok  = push_req && (!full || pop);

  assign entry = {vec_cnt_q[15:0], vec_x, vec_y, vec_z, dut_result, vec_rexp, dut_flags, vec_fexp};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (!start && accept && in_last) state_d = StDone;
      StDone:  if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;
    ovf_d     = ovf_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (start) begin
      vec_cnt_d = '0;
      err_cnt_d = '0;
      ovf_d     = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
    end else begin
      if (accept && (vec_cnt_q != 32'hFFFF_FFFF)) vec_cnt_d = vec_cnt_q + 32'd1;
      if (push_req && (err_cnt_q != 32'hFFFF_FFFF)) err_cnt_d = err_cnt_q + 32'd1;
      if (push_req && !push_ok) ovf_d = 1'b1;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset; it is only observed through the pointers.
  always_ff @(posedge clk) begin
    if (!start && push_ok) mem_q[wr_ptr_q[AW-1:0]] <= entry;
  end

  assign log_valid    = !empty;
  assign log_data     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign busy         = (state_q == StRun);
  assign done         = (state_q == StDone);
  assign log_overflow = ovf_q;
  assign vec_count    = vec_cnt_q;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_fma16_result_checker.sv
// Directed bench for fma16_result_checker with a queue scoreboard of expected log entries.
module tb_fma16_result_checker;

  localparam int unsigned Depth = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, start, in_valid, in_last, log_ready, log_ready1;
  logic [15:0]  vec_x, vec_y, vec_z, vec_rexp, dut_result;
  logic [3:0]   vec_fexp, dut_flags;

  logic         in_ready, log_valid, busy, done, log_overflow;
  logic [103:0] log_data;
  logic [31:0]  vec_count, err_count;

  logic         in_ready1, log_valid1, busy1, done1, log_overflow1;
  logic [103:0] log_data1;
  logic [31:0]  vec_count1, err_count1;

  fma16_result_checker #(.ERR_DEPTH(Depth), .CHECK_FLAGS(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .vec_x(vec_x), .vec_y(vec_y), .vec_z(vec_z), .vec_rexp(vec_rexp),
    .vec_fexp(vec_fexp), .dut_result(dut_result), .dut_flags(dut_flags),
    .log_valid(log_valid), .log_ready(log_ready), .log_data(log_data), .busy(busy),
    .done(done), .log_overflow(log_overflow), .vec_count(vec_count), .err_count(err_count)
  );

  fma16_result_checker #(.ERR_DEPTH(Depth), .CHECK_FLAGS(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
    .in_last(in_last), .vec_x(vec_x), .vec_y(vec_y), .vec_z(vec_z), .vec_rexp(vec_rexp),
    .vec_fexp(vec_fexp), .dut_result(dut_result), .dut_flags(dut_flags),
    .log_valid(log_valid1), .log_ready(log_ready1), .log_data(log_data1), .busy(busy1),
    .done(done1), .log_overflow(log_overflow1), .vec_count(vec_count1),
    .err_count(err_count1)
  );

  int checks = 0;
  int errors = 0;
  logic [103:0] q[$];
  logic [31:0]  m_vec, m_err0, m_err1;
  logic         m_ovf;

  task automatic chk(input string tag, input logic [103:0] obs, input logic [103:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    m_vec = 0; m_err0 = 0; m_err1 = 0; m_ovf = 1'b0;
    q.delete();
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_log_valid"}, log_valid, 0);
    chk({tag, "_log_ovf"}, log_overflow, 0);
    chk({tag, "_vec_count"}, vec_count, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_log_data"}, log_data, 0);
    chk({tag, "_dut1_flat"}, {in_ready1, busy1, done1, log_valid1, log_overflow1,
                              vec_count1, err_count1}, 0);
    chk({tag, "_dut1_log_data"}, log_data1, 0);
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                      input logic [15:0] rexp, input logic [3:0] fexp,
                      input logic [15:0] res, input logic [3:0] flags, input logic last);
    logic mis0, mis1;
    vec_x = x; vec_y = y; vec_z = z; vec_rexp = rexp; vec_fexp = fexp;
    dut_result = res; dut_flags = flags; in_last = last; in_valid = 1'b1;
    #1;
    chk("in_ready", in_ready, 1);
    if (log_ready && q.size() > 0) begin
      chk("pop_head", log_data, q[0]);
      void'(q.pop_front());
    end
    mis0 = (res != rexp);
    mis1 = mis0 || (flags != fexp);
    if (mis0) begin
      if (m_err0 != 32'hFFFF_FFFF) m_err0++;
      if (q.size() < Depth) q.push_back({m_vec[15:0], x, y, z, res, rexp, flags, fexp});
      else m_ovf = 1'b1;
    end
    if (mis1 && m_err1 != 32'hFFFF_FFFF) m_err1++;
    if (m_vec != 32'hFFFF_FFFF) m_vec++;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("vec_count", vec_count, m_vec);
    chk("err_count", err_count, m_err0);
    chk("err_count_flags", err_count1, m_err1);
    chk("log_overflow", log_overflow, m_ovf);
    chk("log_valid", log_valid, q.size() != 0);
  endtask

  task automatic drain;
    while (q.size() > 0) begin
      chk("drain_valid", log_valid, 1);
      chk("drain_data", log_data, q.pop_front());
      log_ready = 1'b1;
      tick();
      log_ready = 1'b0;
    end
    chk("drain_empty", log_valid, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    log_ready = 1'b0; log_ready1 = 1'b1;
    vec_x = '0; vec_y = '0; vec_z = '0; vec_rexp = '0; vec_fexp = '0;
    dut_result = '0; dut_flags = '0;
    model_clear();

    #12;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Records offered in IDLE are ignored.
    in_valid = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    chk("idle_vec_count", vec_count, 0);

    // Three matching records ending the run.
    pulse_start();
    chk("run_busy", busy, 1);
    send(16'h3C00, 16'h3C00, 16'h0000, 16'h3C00, 4'h0, 16'h3C00, 4'h0, 1'b0);
    send(16'h3C00, 16'h3C00, 16'h0000, 16'h3C00, 4'h0, 16'h3C00, 4'h0, 1'b0);
    send(16'h3C00, 16'h3C00, 16'h0000, 16'h3C00, 4'h0, 16'h3C00, 4'h0, 1'b1);
    chk("match_done", done, 1);
    chk("match_busy", busy, 0);
    chk("match_vec3", vec_count, 3);

    // Single mismatch, restarted from DONE.
    pulse_start();
    chk("restart_busy", busy, 1);
    send(16'h3C00, 16'h4000, 16'h0000, 16'h4000, 4'h0, 16'h3FFF, 4'h0, 1'b0);
    chk("mis_log_data", log_data, {16'd0, 16'h3C00, 16'h4000, 16'h0000, 16'h3FFF, 16'h4000,
                                   4'h0, 4'h0});
    drain();

    // Flags-only difference: counted only when CHECK_FLAGS=1.
    pulse_start();
    send(16'h3C00, 16'h3C00, 16'h0000, 16'h3C00, 4'h0, 16'h3C00, 4'h1, 1'b0);
    chk("flags_err0", err_count, 0);
    chk("flags_err1", err_count1, 1);

    // Ten mismatches with no draining: eight logged, overflow sticky.
    pulse_start();
    for (int i = 0; i < 10; i++)
      send(16'(i), 16'h4000, 16'h0001, 16'h4000, 4'h0, 16'(16'h1000 + i), 4'h2, 1'b0);
    chk("ovf_err10", err_count, 10);
    chk("ovf_set", log_overflow, 1);
    drain();
    chk("ovf_sticky", log_overflow, 1);

    // start during RUN blocks input and restarts the run.
    start = 1'b1;
    #1;
    chk("start_blocks_ready", in_ready, 0);
    tick();
    start = 1'b0;
    model_clear();
    chk("restart_vec0", vec_count, 0);
    chk("restart_ovf0", log_overflow, 0);

    // Fill, then push and pop together on a full FIFO.
    for (int i = 0; i < 8; i++)
      send(16'h0100, 16'(i), 16'h0000, 16'h2000, 4'h0, 16'h2001, 4'h0, 1'b0);
    log_ready = 1'b1;
    send(16'h0200, 16'h0008, 16'h0000, 16'h2000, 4'h0, 16'h2002, 4'h0, 1'b0);
    log_ready = 1'b0;
    chk("fullpp_ovf", log_overflow, 0);
    chk("fullpp_depth", q.size(), 8);
    drain();

    // Asynchronous reset mid-run.
    pulse_start();
    for (int i = 0; i < 5; i++)
      send(16'(i), 16'h0000, 16'h0000, 16'h1111, 4'h0, 16'((i % 2 == 0) ? 16'h1111 : 16'h2222),
           4'h0, 1'b0);
    chk("pre_reset_valid", log_valid, 1);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_clear();
    #2;
    reset_n = 1'b1;
    pulse_start();
    chk("post_reset_vec0", vec_count, 0);
    send(16'h3C00, 16'h3C00, 16'h0000, 16'h3C00, 4'h0, 16'h3C00, 4'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
